data_mem_io: RTL and testbench
==============================

# data_mem_io

Data-memory stage for the pipelined RISC-V core. Consumes the core's memory-stage outputs (`MemWriteM`, `ALUResult` as address, `WriteData`) and returns `ReadData` in the same cycle. Decodes a small word RAM plus three memory-mapped registers: a GPIO output, a free-running cycle counter and a `tohost` halt register. The bench and FPGA top use it to observe program results and detect end of test.

## Interface
Parameters:
- `DEPTH`, 64: RAM size in 32-bit words; power of two, at least 4.
- `INIT_FILE`, "": hex image loaded into RAM at elaboration; empty means no load.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWriteM` in 1: store strobe from the memory stage.
- `ALUResult` in 32: byte address from the memory stage.
- `WriteData` in 32: store data.
- `ReadData` out 32: load data, combinational from the address.
- `gpio_out` out 32: GPIO register value.
- `halt` out 1: sticky; set by the first nonzero `tohost` store.
- `halt_code` out 32: value of the first nonzero `tohost` store.
- `bad_access` out 1: sticky; set by any store to an unmapped address.

## Operation
Address map (`addr[1:0]` ignored; all accesses are full words):
- RAM: `0x0000_0000` to `DEPTH*4-1`. Index is `addr[log2(DEPTH)+1:2]`.
- `0x8000_0000` GPIO: read/write.
- `0x8000_0004` CYCLE: read returns the counter; a write loads the counter.
- `0x8000_0008` TOHOST: read returns `halt_code`; a write is handled as below.
- Any other address is unmapped: reads return 0; writes are dropped and set `bad_access`.

Behaviour:
- Reads are asynchronous (combinational). `ReadData` always reflects the current address, regardless of `MemWriteM`.
- Writes commit on the rising `clk` edge when `MemWriteM`=1. Only the addressed location changes.
- CYCLE is a 32-bit counter:
  - Increments by 1 every cycle while `halt`=0, wrapping `0xFFFF_FFFF` to 0.
  - A write to CYCLE takes priority over the increment in that cycle: the written value is loaded, and incrementing resumes on the next edge.
  - The counter holds its value while `halt`=1. Writes to it are still accepted.
- TOHOST:
  - A store with nonzero data while `halt`=0 sets `halt`=1 and latches the data into `halt_code`.
  - A store of zero is ignored.
  - Any store while `halt`=1 is ignored, so the first code is kept.
- RAM and GPIO writes remain functional after `halt`.
- `bad_access`, once set, clears only on reset.

## Timing
Reset values (asynchronous, while `reset`=0):
- `gpio_out`=0, CYCLE=0, `halt`=0, `halt_code`=0, `bad_access`=0.
- RAM contents are not reset; they keep their current values or the `INIT_FILE` image.

Latency and ordering:
- Load latency is 0 cycles (same-cycle combinational path).
- Store-to-load latency is 1 cycle: the new value is visible after the writing edge.
- A read and write to the same address in one cycle returns the old value on `ReadData`.
- After a write to CYCLE of V at edge n, a read during cycle n+1 returns V, and a read during cycle n+2 returns V+1 (when not halted).

Status outputs:
- `halt` and `halt_code` update on the edge that commits the `tohost` store.
- `bad_access` rises on the edge following the offending store.

Reset behaviour:
- Releasing `reset` is synchronised by the user.
- Asserting `reset` mid-test clears all registers immediately, including a pending halt.

## Test plan
- Reset, then 5 idle cycles → `gpio_out`=0, `halt`=0, `bad_access`=0; reading `0x8000_0004` returns 5 (±0 counted from the first edge after release).
- Store `0xDEADBEEF` to `0x10`, then load `0x10` and `0x13` → both return `0xDEADBEEF`. Load `0x14` in the write cycle and the next cycle → shows the old and new content of its own word, unaffected by the store to `0x10`.
- Store `0xFFFF_FFFE` to CYCLE → reads over the next cycles give `0xFFFF_FFFE`, `0xFFFF_FFFF`, 0, 1 (wrap-around).
- Store 0 to TOHOST → `halt` stays 0. Then store 7 → `halt`=1, `halt_code`=7, CYCLE frozen. Then store 9 → `halt_code` remains 7; a GPIO store of `0xA5` still gives `gpio_out`=`0xA5`.
- Store to `0x4000_0000` → `bad_access`=1 next cycle and no RAM word changes. Load `0x8000_000C` → returns 0.
- Halt with `halt_code`=3, then pulse `reset` low for 1 cycle asynchronously mid-clock → `halt`, `halt_code`, CYCLE and `gpio_out` go to 0 immediately, while RAM contents are retained.

Source files
------------

// File: rtl/data_mem_io.sv
// Data-memory stage for the pipelined RISC-V core.
// Word RAM plus three memory-mapped registers (GPIO, free-running cycle
// counter, tohost halt register). Loads are combinational, stores commit on
// the rising clock edge. addr[1:0] is ignored: every access is a full word.
module data_mem_io #(
    parameter int    DEPTH     = 64,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        bad_access
);

    localparam int AW = $clog2(DEPTH);

    // Word addresses (byte address >> 2) of the memory-mapped registers.
    localparam logic [29:0] GPIO_WADDR   = 30'h2000_0000;
    localparam logic [29:0] CYCLE_WADDR  = 30'h2000_0001;
    localparam logic [29:0] TOHOST_WADDR = 30'h2000_0002;

    typedef enum logic [2:0] {
        SEL_RAM    = 3'd0,
        SEL_GPIO   = 3'd1,
        SEL_CYCLE  = 3'd2,
        SEL_TOHOST = 3'd3,
        SEL_NONE   = 3'd4
    } sel_e;

    logic [31:0]   mem_r [DEPTH];
    logic [31:0]   gpio_r;
    logic [31:0]   cycle_r;
    logic          halt_r;
    logic [31:0]   halt_code_r;
    logic          bad_access_r;

    logic [29:0]   word_addr_s;
    logic [AW-1:0] ram_idx_s;
    logic          ram_hit_s;
    sel_e          sel_s;
    logic [31:0]   rdata_s;
    logic [31:0]   cycle_nxt_s;
    logic          we_ram_s;
    logic          we_gpio_s;
    logic          we_cycle_s;
    logic          we_tohost_s;
    logic          we_bad_s;
    logic          unused_low_s;

    assign word_addr_s  = ALUResult[31:2];
    assign ram_idx_s    = ALUResult[AW+1:2];
    assign ram_hit_s    = (ALUResult[31:AW+2] == {(30-AW){1'b0}});
    assign unused_low_s = ^ALUResult[1:0];

    // Address decode: pick exactly one target (or none) for the current access.
    always_comb begin
        sel_s = SEL_NONE;
        if (ram_hit_s) begin
            sel_s = SEL_RAM;
        end else begin
            case (word_addr_s)
                GPIO_WADDR:   sel_s = SEL_GPIO;
                CYCLE_WADDR:  sel_s = SEL_CYCLE;
                TOHOST_WADDR: sel_s = SEL_TOHOST;
                default:      sel_s = SEL_NONE;
            endcase
        end
    end

    // Per-target write strobes; an unmapped store only raises the sticky error.
    always_comb begin
        we_ram_s    = MemWriteM && (sel_s == SEL_RAM);
        we_gpio_s   = MemWriteM && (sel_s == SEL_GPIO);
        we_cycle_s  = MemWriteM && (sel_s == SEL_CYCLE);
        we_tohost_s = MemWriteM && (sel_s == SEL_TOHOST);
        we_bad_s    = MemWriteM && (sel_s == SEL_NONE);
    end

    // Combinational load path; shows pre-edge contents during a store.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (sel_s)
            SEL_RAM:    rdata_s = mem_r[ram_idx_s];
            SEL_GPIO:   rdata_s = gpio_r;
            SEL_CYCLE:  rdata_s = cycle_r;
            SEL_TOHOST: rdata_s = halt_code_r;
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Cycle counter next value: a store wins over counting, halt freezes counting.
    always_comb begin
        cycle_nxt_s = cycle_r;
        if (we_cycle_s) begin
            cycle_nxt_s = WriteData;
        end else if (!halt_r) begin
            cycle_nxt_s = cycle_r + 32'd1;
        end else begin
            cycle_nxt_s = cycle_r;
        end
    end

    // RAM word write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_ram_s) begin
            mem_r[ram_idx_s] <= WriteData;
        end
    end

    // GPIO output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_r <= 32'h0000_0000;
        end else if (we_gpio_s) begin
            gpio_r <= WriteData;
        end
    end

    // Free-running cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_nxt_s;
        end
    end

    // Tohost: first nonzero store halts and keeps its code; later stores ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_r      <= 1'b0;
            halt_code_r <= 32'h0000_0000;
        end else if (we_tohost_s && !halt_r && (WriteData != 32'h0000_0000)) begin
            halt_r      <= 1'b1;
            halt_code_r <= WriteData;
        end
    end

    // Sticky flag for stores to unmapped addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_access_r <= 1'b0;
        end else if (we_bad_s) begin
            bad_access_r <= 1'b1;
        end
    end

    assign ReadData   = rdata_s;
    assign gpio_out   = gpio_r;
    assign halt       = halt_r;
    assign halt_code  = halt_code_r;
    assign bad_access = bad_access_r;

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed vector table, reset corner
// sequence, then randomized traffic against a behavioural memory-map model.
module tb_data_mem_io;

    localparam int DEPTH = 64;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_CYC  = 32'h8000_0004;
    localparam logic [31:0] A_TOH  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic        halt;
    logic [31:0] halt_code;
    logic        bad_access;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_pre;

    // Reference model state
    logic [31:0] m_ram [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_gpio, m_cyc, m_code;
    bit          m_halt, m_bad;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] rd;
        bit          halt;
        logic [31:0] code;
        logic [31:0] gpio;
        bit          bad;
    } vec_t;
    vec_t tbl[$];

    data_mem_io #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .gpio_out(gpio_out),
        .halt(halt), .halt_code(halt_code), .bad_access(bad_access)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a < DEPTH * 4) begin
            known = m_known[a / 4];
            return m_ram[a / 4];
        end
        if ((a & ~32'h3) == A_GPIO) return m_gpio;
        if ((a & ~32'h3) == A_CYC)  return m_cyc;
        if ((a & ~32'h3) == A_TOH)  return m_code;
        return 32'h0;
    endfunction

    task automatic m_commit(input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w;
        w = a & ~32'h3;
        if (we && w == A_CYC) m_cyc = wd;
        else if (!m_halt)     m_cyc = m_cyc + 32'd1;
        if (we) begin
            if (a < DEPTH * 4) begin
                m_ram[a / 4]   = wd;
                m_known[a / 4] = 1'b1;
            end else if (w == A_GPIO) begin
                m_gpio = wd;
            end else if (w == A_TOH) begin
                if (!m_halt && wd != 32'h0) begin
                    m_halt = 1'b1;
                    m_code = wd;
                end
            end else if (w != A_CYC) begin
                m_bad = 1'b1;
            end
        end
    endtask

    task automatic m_reset();
        m_gpio = 32'h0; m_cyc = 32'h0; m_code = 32'h0;
        m_halt = 1'b0;  m_bad = 1'b0;
    endtask

    // One bus cycle: drive at negedge, sample load before the edge, status after.
    task automatic apply(input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp;
        bit known;
        @(negedge clk);
        MemWriteM = we; ALUResult = a; WriteData = wd;
        #1;
        rd_pre = ReadData;
        exp = m_read(a, known);
        if (known) chk("rd_model", rd_pre, exp);
        @(posedge clk);
        m_commit(we, a, wd);
        #1;
        chk("gpio_model", gpio_out, m_gpio);
        chk("halt_model", {31'h0, halt}, {31'h0, m_halt});
        chk("code_model", halt_code, m_code);
        chk("bad_model", {31'h0, bad_access}, {31'h0, m_bad});
    endtask

    // Asynchronous reset pulse asserted mid-cycle, released just after an edge.
    task automatic pulse_reset();
        MemWriteM = 1'b0; ALUResult = A_CYC; WriteData = 32'h0;
        #1;
        reset = 1'b0;
        #1;
        chk("rst_halt", {31'h0, halt}, 32'h0);
        chk("rst_code", halt_code, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_bad", {31'h0, bad_access}, 32'h0);
        chk("rst_cycle", ReadData, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        m_reset();
    endtask

    task automatic add(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit c, input logic [31:0] rd, input bit h,
                       input logic [31:0] code, input logic [31:0] g, input bit b);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.chk_rd = c; v.rd = rd;
        v.halt = h; v.code = code; v.gpio = g; v.bad = b;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] a, wd;
        bit we;

        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_ram[i]   = 32'h0;
        end
        m_reset();

        // Directed table; during step k (k < 13) the counter reads k.
        for (int i = 0; i < 5; i++) add(0, A_GPIO, 0, 1, 0, 0, 0, 0, 0);
        add(0, A_CYC, 0, 1, 32'd5, 0, 0, 0, 0);
        add(1, 32'h14, 32'h1414_1414, 0, 0, 0, 0, 0, 0);
        add(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        add(0, 32'h10, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add(0, 32'h13, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add(1, 32'h14, 32'h5555_AAAA, 1, 32'h1414_1414, 0, 0, 0, 0);
        add(0, 32'h14, 0, 1, 32'h5555_AAAA, 0, 0, 0, 0);
        add(0, 32'h10, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add(1, A_CYC, 32'hFFFF_FFFE, 1, 32'd13, 0, 0, 0, 0);
        add(0, A_CYC, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        add(0, A_CYC, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        add(0, A_CYC, 0, 1, 32'h0, 0, 0, 0, 0);
        add(0, A_CYC, 0, 1, 32'h1, 0, 0, 0, 0);
        add(1, A_TOH, 32'h0, 1, 32'h0, 0, 0, 0, 0);
        add(1, A_TOH, 32'h7, 1, 32'h0, 1, 7, 0, 0);
        add(0, A_CYC, 0, 1, 32'd4, 1, 7, 0, 0);
        add(0, A_CYC, 0, 1, 32'd4, 1, 7, 0, 0);
        add(1, A_TOH, 32'h9, 1, 32'h7, 1, 7, 0, 0);
        add(1, A_GPIO, 32'hA5, 1, 32'h0, 1, 7, 32'hA5, 0);
        add(0, A_GPIO, 0, 1, 32'hA5, 1, 7, 32'hA5, 0);
        add(1, 32'h4000_0010, 32'hFFFF_FFFF, 1, 32'h0, 1, 7, 32'hA5, 1);
        add(0, 32'h8000_000C, 0, 1, 32'h0, 1, 7, 32'hA5, 1);
        add(0, 32'h10, 0, 1, 32'hDEAD_BEEF, 1, 7, 32'hA5, 1);
        add(0, 32'h14, 0, 1, 32'h5555_AAAA, 1, 7, 32'hA5, 1);
        add(1, A_CYC, 32'd100, 1, 32'd4, 1, 7, 32'hA5, 1);
        add(0, A_CYC, 0, 1, 32'd100, 1, 7, 32'hA5, 1);
        add(0, A_CYC, 0, 1, 32'd100, 1, 7, 32'hA5, 1);
        add(0, 32'h8000_0001, 0, 1, 32'hA5, 1, 7, 32'hA5, 1);

        reset = 1'b0; MemWriteM = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].addr, tbl[i].wd);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rd_pre, tbl[i].rd);
            chk($sformatf("tbl%0d_halt", i), {31'h0, halt}, {31'h0, tbl[i].halt});
            chk($sformatf("tbl%0d_code", i), halt_code, tbl[i].code);
            chk($sformatf("tbl%0d_gpio", i), gpio_out, tbl[i].gpio);
            chk($sformatf("tbl%0d_bad", i), {31'h0, bad_access}, {31'h0, tbl[i].bad});
        end

        // Halt with code 3, then reset mid-cycle: registers clear, RAM survives.
        pulse_reset();
        apply(1, A_GPIO, 32'h3C);
        apply(1, A_TOH, 32'h3);
        chk("seq_halt", {31'h0, halt}, 32'h1);
        chk("seq_code", halt_code, 32'h3);
        chk("seq_gpio", gpio_out, 32'h3C);
        pulse_reset();
        apply(0, 32'h10, 32'h0);
        chk("seq_ram10", rd_pre, 32'hDEAD_BEEF);
        apply(0, 32'h14, 32'h0);
        chk("seq_ram14", rd_pre, 32'h5555_AAAA);
        apply(0, A_CYC, 32'h0);
        chk("seq_cyc", rd_pre, 32'd2);

        // Randomized traffic against the model, with periodic resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) pulse_reset();
            we = ($urandom_range(0, 1) == 1);
            wd = $urandom();
            case ($urandom_range(0, 5))
                0, 1: a = $urandom_range(0, DEPTH * 4 - 1);
                2:    a = A_GPIO | $urandom_range(0, 3);
                3:    a = A_CYC | $urandom_range(0, 3);
                4: begin
                    a = A_TOH | $urandom_range(0, 3);
                    if ($urandom_range(0, 1) == 0) wd = 32'h0;
                end
                default: a = ($urandom_range(0, 1) == 0) ? 32'h8000_000C : $urandom();
            endcase
            apply(we, a, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
